// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: one-at-a-time command -> register-block request/ack bridge with timeout.
// Ports:
//   clk, reset_L                        clock, async active-low reset
//   cmd_valid/cmd_ready                 command handshake
//   cmd_rd_wr, cmd_addr, cmd_wdata      command fields (1 = read)
//   req, rd_wr, addr, write_val         request pulse + held command to register block
//   ack, read_val                       completion pulse + read data from register block
//   rsp_valid/rsp_ready                 response handshake
//   rsp_rdata, rsp_timeout              response payload
//   stray_ack                           sticky: ack seen with no transaction waiting
module reg_access_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset_L,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rd_wr,
    input  logic [3:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        req,
    output logic        rd_wr,
    output logic [3:0]  addr,
    output logic [31:0] write_val,
    input  logic        ack,
    input  logic [31:0] read_val,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        stray_ack
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT_CYC - 1);
    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        cmd_ready_q, req_q, rd_wr_q, rsp_valid_q, rsp_timeout_q, stray_q;
    logic [3:0]  addr_q;
    logic [31:0] write_val_q, rsp_rdata_q;
    assign cmd_ready   = cmd_ready_q;
    assign req         = req_q;
    assign rd_wr       = rd_wr_q;
    assign addr        = addr_q;
    assign write_val   = write_val_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;
    assign stray_ack   = stray_q;
    // cmd_ready is registered so it stays low until the first edge after reset release
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            req_q         <= 1'b0;
            rd_wr_q       <= 1'b0;
            addr_q        <= '0;
            write_val_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
            stray_q       <= 1'b0;
        end else begin
            req_q <= 1'b0;
            if (ack && (state_q == IDLE || state_q == RSP))
                stray_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        rd_wr_q     <= cmd_rd_wr;
                        addr_q      <= cmd_addr;
                        write_val_q <= cmd_wdata;
                        req_q       <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        state_q     <= REQ;
                    end
                end
                REQ, WAIT: begin
                    if (ack) begin
                        rsp_rdata_q   <= rd_wr_q ? read_val : 32'h0;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RSP;
                    end else if (state_q == REQ) begin
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end else if (cnt_q == LAST) begin
                        rsp_rdata_q   <= 32'h0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RSP;
                    end else begin
                        cnt_q <= cnt_q + {7'b0, cnt_q != 8'hFF};
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
